// File: rtl/apb_pkg.sv
// Shared APB definitions: bus width defaults, master FSM encoding and word-alignment helper.
package apb_pkg;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
  endfunction
endpackage

// File: rtl/apb_if.sv
// APB3 bus bundle between one master and one slave.
interface apb_if import apb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input pready, prdata);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output pready, prdata);
endinterface

// File: rtl/apb_sram.sv
// APB3 SRAM slave with programmable wait states and a stall input that holds pready low.
module apb_sram import apb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] wait_states,
  input  logic       stall,
  apb_if.slave       apb
);
  localparam int AW    = ADDR_W - 2;
  localparam int DEPTH = 2 ** AW;

  logic [3:0] wait_cnt;
  logic       access;
  logic       wr_en;
  logic       unused_addr_lsb;

  assign access     = apb.psel && apb.penable;
  assign apb.pready = !stall && (wait_cnt == wait_states);
  assign wr_en      = access && apb.pready && apb.pwrite;
  assign unused_addr_lsb = ^apb.paddr[1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      wait_cnt <= 4'd0;
    else if (access && !apb.pready) wait_cnt <= wait_cnt + 4'd1;
    else                            wait_cnt <= 4'd0;
  end

  apb_sram_mem #(.DEPTH(DEPTH), .AW(AW), .DATA_W(DATA_W)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .addr  (apb.paddr[ADDR_W-1:2]),
    .wdata (apb.pwdata),
    .rdata (apb.prdata)
  );
endmodule

// File: rtl/apb_sram_mem.sv
// Word-addressed storage array with synchronous write and combinational read.
module apb_sram_mem #(
  parameter int DEPTH  = 1024,
  parameter int AW     = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS-phase wait counter; expire flags the last permitted non-ready cycle.
module apb_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        cnt <= '0;
    else if (clear)                   cnt <= '0;
    else if (enable && cnt != LIMIT)  cnt <= cnt + ONE;
  end

  // This cycle's increment would bring the count to the limit.
  assign expire = (TIMEOUT_CYC != 0) && enable && ((cnt + ONE) == LIMIT);
endmodule

// File: rtl/apb_cmd_master.sv
// APB3 master: one valid/ready command in, one SETUP/ACCESS transfer, one valid/ready response out.
//   state     | meaning
//   ST_IDLE   | cmd_ready high, waiting for a command
//   ST_SETUP  | psel=1, penable=0 for one cycle
//   ST_ACCESS | psel=penable=1 until pready or timeout
//   ST_RESP   | rsp_valid held until rsp_ready
module apb_cmd_master import apb_pkg::*; #(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  apb_if.master             apb
);
  apb_state_t        state_q, state_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              timeout;

  apb_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (state_q != ST_ACCESS),
    .enable (state_q == ST_ACCESS && !apb.pready),
    .expire (timeout)
  );

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      ST_IDLE: if (cmd_valid) begin
        rsp_write_d = cmd_write;
        // A misaligned command never touches the bus, so paddr keeps its last value.
        if (is_word_aligned(cmd_addr[1:0])) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_RESP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: if (apb.pready || timeout) begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = !apb.pready;
        rsp_rdata_d = (apb.pready && !pwrite_q) ? apb.prdata : '0;
        state_d     = ST_RESP;
      end
      ST_RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench: apb_cmd_master driving apb_sram, with memory contents checked through the hierarchy.
module tb_apb_cmd_master;
  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  wait_states;
  logic        stall;

  int          n_checks = 0;
  int          n_fail = 0;
  int          psel_cyc = 0;
  int          pen_cyc = 0;
  bit          paddr_bad = 0;
  bit          pen_wo_sel = 0;
  bit          hold_bad;
  logic [11:0] exp_paddr = '0;
  logic        r_write, r_err;
  logic [31:0] r_rdata;

  apb_if apb ();

  apb_cmd_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYC(16)) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (apb)
  );

  apb_sram u_apb_sram (
    .clk         (clk),
    .rstn        (rstn),
    .wait_states (wait_states),
    .stall       (stall),
    .apb         (apb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (apb.psel === 1'b1) psel_cyc++;
    if (apb.penable === 1'b1) pen_cyc++;
    if (apb.psel === 1'b1 && apb.paddr !== exp_paddr) paddr_bad = 1;
    if (apb.penable === 1'b1 && apb.psel !== 1'b1) pen_wo_sel = 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    psel_cyc = 0;
    pen_cyc  = 0;
  endtask

  task automatic send_cmd(input logic w, input logic [11:0] a, input logic [31:0] d);
    int k = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("cmd_accept_bound", 32'(k < 50), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (rsp_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rsp_valid_bound", 32'(k < 100), 32'd1);
  endtask

  task automatic take_rsp();
    r_write = rsp_write; r_rdata = rsp_rdata; r_err = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic wait_rsp();
    wait_valid();
    take_rsp();
  endtask

  initial begin
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; wait_states = 4'd0; stall = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_psel", apb.psel, 0);
    check("rst_penable", apb.penable, 0);
    check("rst_pwrite", apb.pwrite, 0);
    check("rst_paddr", apb.paddr, 0);
    check("rst_pwdata", apb.pwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    rstn = 1'b1;
    @(negedge clk);

    // 1: write top word, zero wait states
    clear_mon(); exp_paddr = 12'hFFC;
    send_cmd(1'b1, 12'hFFC, 32'hDEADBEEF);
    wait_rsp();
    check("t1_err", r_err, 0);
    check("t1_write", r_write, 1);
    check("t1_rdata", r_rdata, 0);
    check("t1_mem", u_apb_sram.u_mem.mem[1023], 32'hDEADBEEF);
    check("t1_psel_cycles", psel_cyc, 2);
    check("t1_penable_cycles", pen_cyc, 1);

    // 2: preload word 0, then read it back with 3 wait states
    exp_paddr = 12'h000;
    send_cmd(1'b1, 12'h000, 32'h12345678);
    wait_rsp();
    check("t2_preload_mem", u_apb_sram.u_mem.mem[0], 32'h12345678);
    wait_states = 4'd3; clear_mon(); paddr_bad = 0;
    send_cmd(1'b0, 12'h000, 32'h0);
    wait_rsp();
    check("t2_rdata", r_rdata, 32'h12345678);
    check("t2_err", r_err, 0);
    check("t2_write", r_write, 0);
    check("t2_penable_cycles", pen_cyc, 4);
    check("t2_psel_cycles", psel_cyc, 5);
    check("t2_paddr_stable", paddr_bad, 0);
    wait_states = 4'd0;

    // 3: misaligned read
    clear_mon();
    send_cmd(1'b0, 12'h002, 32'h0);
    wait_rsp();
    check("t3_err", r_err, 1);
    check("t3_rdata", r_rdata, 0);
    check("t3_psel_cycles", psel_cyc, 0);
    check("t3_cmd_ready", cmd_ready, 1);

    exp_paddr = 12'hFFC;
    send_cmd(1'b0, 12'hFFC, 32'h0);
    wait_rsp();
    check("rd_top_rdata", r_rdata, 32'hDEADBEEF);

    // 4: pready stuck low -> timeout after 16 ACCESS cycles
    stall = 1'b1; clear_mon(); exp_paddr = 12'h004;
    send_cmd(1'b0, 12'h004, 32'h0);
    wait_valid();
    check("t4_err", rsp_err, 1);
    check("t4_rdata", rsp_rdata, 0);
    check("t4_psel_dropped", apb.psel, 0);
    check("t4_penable_dropped", apb.penable, 0);
    check("t4_cmd_ready_busy", cmd_ready, 0);
    check("t4_penable_cycles", pen_cyc, 16);
    check("t4_psel_cycles", psel_cyc, 17);
    take_rsp();
    check("t4_cmd_ready_back", cmd_ready, 1);
    stall = 1'b0;

    // 5: response back-pressure while the next command waits
    exp_paddr = 12'h000;
    send_cmd(1'b0, 12'h000, 32'h0);
    wait_valid();
    clear_mon(); hold_bad = 0;
    exp_paddr = 12'h008;
    cmd_write = 1'b1; cmd_addr = 12'h008; cmd_wdata = 32'hA5A5A5A5; cmd_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || cmd_ready !== 1'b0) hold_bad = 1;
    end
    check("t5_hold", hold_bad, 0);
    check("t5_no_apb_while_held", psel_cyc, 0);
    take_rsp();
    check("t5_rdata", r_rdata, 32'h12345678);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp();
    check("t5_next_err", r_err, 0);
    check("t5_next_mem", u_apb_sram.u_mem.mem[2], 32'hA5A5A5A5);

    // 6: reset asserted during ACCESS
    stall = 1'b1; exp_paddr = 12'h004;
    send_cmd(1'b0, 12'h004, 32'h0);
    @(negedge clk);
    check("t6_in_access", apb.penable, 1);
    #2 rstn = 1'b0;
    #1;
    check("t6_psel_async", apb.psel, 0);
    check("t6_penable_async", apb.penable, 0);
    check("t6_rsp_valid_async", rsp_valid, 0);
    check("t6_cmd_ready_async", cmd_ready, 1);
    @(negedge clk);
    stall = 1'b0; rstn = 1'b1;
    @(negedge clk);
    exp_paddr = 12'h000;
    send_cmd(1'b1, 12'h000, 32'hCAFEF00D);
    wait_rsp();
    check("t6_post_err", r_err, 0);
    check("t6_post_write", r_write, 1);
    check("t6_post_mem", u_apb_sram.u_mem.mem[0], 32'hCAFEF00D);

    check("penable_implies_psel", pen_wo_sel, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
